mixer_duc_mul_arbiter: RTL and testbench

Shares one pipelined signed 16x8 multiplier between NUM_REQ requesters, for example the I/Q mixer lanes of the DUC. Arbitration is round-robin. Each requester has a valid/ready operand port. Every result comes back on one shared output stream, tagged with the ID of the requester that issued it. The block is placed between the mixer_duc datapath lanes and a single DSP48 multiply resource, so the lanes do not each need their own multiplier.

---
 rtl/mixer_duc_mul_arbiter.sv | 151 +++++++++++++++
 tb/tb_mixer_duc_mul_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_duc_mul_arbiter.sv
// rtl/mixer_duc_mul_arbiter.sv - round-robin arbiter sharing one pipelined signed multiplier
module mixer_duc_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 8,
    parameter int P_WIDTH  = 24,
    parameter int MUL_LAT  = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         cfg_enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [P_WIDTH-1:0]           res_data,
    output logic [ID_WIDTH-1:0]          res_id,
    output logic                         busy
);

    // Full-precision signed product; both operands sign-extended to the product width.
    function automatic logic [P_WIDTH-1:0] smul(input logic [A_WIDTH-1:0] a,
                                                input logic [B_WIDTH-1:0] b);
        logic signed [P_WIDTH-1:0] ax;
        logic signed [P_WIDTH-1:0] bx;
        ax = $signed({{B_WIDTH{a[A_WIDTH-1]}}, a});
        bx = $signed({{A_WIDTH{b[B_WIDTH-1]}}, b});
        return ax * bx;
    endfunction

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_next;
    logic [ID_WIDTH-1:0] win;
    logic                grant;
    logic                stall;
    logic [A_WIDTH-1:0]  sel_a;
    logic [B_WIDTH-1:0]  sel_b;

    logic [MUL_LAT-1:0]  vld;
    logic [ID_WIDTH-1:0] tag [MUL_LAT];
    logic [P_WIDTH-1:0]  out_p;

    assign res_valid = vld[MUL_LAT-1];
    assign res_id    = tag[MUL_LAT-1];
    assign res_data  = out_p;
    assign busy      = |vld;
    assign stall     = res_valid & ~res_ready;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid index overall (wrap).
    always_comb begin
        logic                hit_hi;
        logic                hit_lo;
        logic [ID_WIDTH-1:0] win_hi;
        logic [ID_WIDTH-1:0] win_lo;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                hit_lo = 1'b1;
                win_lo = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    win_hi = ID_WIDTH'(i);
                end
            end
        end
        win   = hit_hi ? win_hi : win_lo;
        grant = hit_lo & ap_rst_n & cfg_enable & ~stall;
        ptr_next = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
    end

    // One-hot ready for the winner and operand mux for the multiplier input.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_WIDTH'(i)) begin
                req_ready[i] = grant;
                sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Valid/tag shift chain and pointer; the whole pipeline freezes while the output is stalled.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
            ptr <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag[k] <= '0;
            end
        end else if (!stall) begin
            vld[0] <= grant;
            if (grant) begin
                tag[0] <= win;
                ptr    <= ptr_next;
            end
            for (int k = 1; k < MUL_LAT; k++) begin
                vld[k] <= vld[k-1];
                tag[k] <= tag[k-1];
            end
        end
    end

    generate
        if (MUL_LAT == 1) begin : g_lat1
            // Single-stage case: the multiply happens before the only (output) register.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    out_p <= '0;
                end else if (!stall && grant) begin
                    out_p <= smul(sel_a, sel_b);
                end
            end
        end else begin : g_latn
            logic [A_WIDTH-1:0] op_a;
            logic [B_WIDTH-1:0] op_b;
            logic [P_WIDTH-1:0] pq [1:MUL_LAT-1];

            // Stage 0 registers the granted operands; the multiply sits between stage 0 and 1.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    op_a <= '0;
                    op_b <= '0;
                    for (int k = 1; k < MUL_LAT; k++) begin
                        pq[k] <= '0;
                    end
                end else if (!stall) begin
                    if (grant) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                    end
                    pq[1] <= smul(op_a, op_b);
                    for (int k = 2; k < MUL_LAT; k++) begin
                        pq[k] <= pq[k-1];
                    end
                end
            end

            assign out_p = pq[MUL_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_mixer_duc_mul_arbiter.sv
// tb/tb_mixer_duc_mul_arbiter.sv - directed scoreboard bench for mixer_duc_mul_arbiter
module tb_mixer_duc_mul_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int BW = 8;
    localparam int PW = 24;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_enable;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [PW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            busy;

    always #5 clk = ~clk;

    mixer_duc_mul_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LAT(2)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .cfg_enable(cfg_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [PW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    int   n_disc = 0;
    int   mptr   = 0;
    int   left[NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mulx(input logic [AW-1:0] a, input logic [BW-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[PW-1:0];
    endfunction

    // Reference round-robin arbiter driven by the bench's own pointer.
    function automatic logic [NR-1:0] model_rdy();
        logic [NR-1:0] r;
        int pick;
        int idx;
        r = '0;
        pick = -1;
        if (!rst_n || !cfg_enable || (res_valid && !res_ready) || req_valid == '0) return r;
        for (int k = 0; k < NR; k++) begin
            idx = (mptr + k) % NR;
            if (pick < 0 && req_valid[idx]) pick = idx;
        end
        r[pick] = 1'b1;
        return r;
    endfunction

    task automatic post(input int i, input int n, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
        req_valid[i]      = 1'b1;
        left[i]           = n - 1;
    endtask

    task automatic post_rand(input int i, input int n);
        post(i, n, AW'($urandom()), BW'($urandom()));
    endtask

    // One clock: check the grant against the model, then requesters react to accepted operands.
    task automatic step();
        logic [NR-1:0] e;
        logic [NR-1:0] g;
        @(negedge clk);
        e = model_rdy();
        chk("req_ready", 32'(req_ready), 32'(e));
        for (int i = 0; i < NR; i++) if (e[i]) mptr = (i + 1) % NR;
        g = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                if (left[i] > 0) begin
                    left[i]--;
                    req_a[i*AW +: AW] = AW'($urandom());
                    req_b[i*BW +: BW] = BW'($urandom());
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || req_valid != '0) && k < 80) begin
            step();
            k++;
        end
        chk("drain_idle", 32'({busy, |req_valid}), 32'd0);
    endtask

    // Scoreboard: push on every accepted operand, pop/compare on every accepted result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = IW'(i);
                    e.data = mulx(req_a[i*AW +: AW], req_b[i*BW +: BW]);
                    sb.push_back(e);
                    n_push++;
                end
            end
            if (res_valid && res_ready) begin
                n_pop++;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_id", 32'(res_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_enable = 1'b1;
        res_ready  = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < NR; i++) left[i] = 0;

        // reset state
        step();
        step();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        rst_n = 1'b1;
        mptr  = 0;

        // single request from requester 2, exact latency
        post(2, 1, 16'h1234, 8'h05);
        step();
        chk("single_early", 32'(res_valid), 32'd0);
        step();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'h005B04);
        chk("single_id", 32'(res_id), 32'd2);
        drain();

        // all four requesters streaming
        for (int i = 0; i < NR; i++) post_rand(i, 6);
        repeat (24) step();
        drain();
        chk("stream_count", 32'(n_pop), 32'(n_push));

        // extreme operands
        post(0, 1, 16'h8000, 8'h80);
        step();
        post(0, 1, 16'h8000, 8'h7F);
        step();
        chk("ext_valid", 32'(res_valid), 32'd1);
        chk("ext_min_min", 32'(res_data), 32'h400000);
        step();
        chk("ext_min_max", 32'(res_data), 32'hC08000);
        chk("ext_id", 32'(res_id), 32'd0);
        drain();

        // backpressure on a stream from requester 1
        post_rand(1, 5);
        step();
        step();
        res_ready = 1'b0;
        chk("bp_valid0", 32'(res_valid), 32'd1);
        repeat (5) begin
            step();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", 32'(res_data), 32'(sb[0].data));
            chk("bp_id", 32'(res_id), 32'd1);
        end
        res_ready = 1'b1;
        drain();
        chk("bp_count", 32'(n_pop), 32'(n_push));
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // cfg_enable dropped with two operations in flight
        for (int i = 0; i < NR; i++) post_rand(i, 3);
        step();
        step();
        cfg_enable = 1'b0;
        chk("dis_busy", 32'(busy), 32'd1);
        repeat (4) step();
        chk("dis_idle", 32'(busy), 32'd0);
        chk("dis_count", 32'(n_pop), 32'(n_push));
        cfg_enable = 1'b1;
        drain();

        // asynchronous reset with a full pipeline
        for (int i = 0; i < NR; i++) post_rand(i, 10);
        repeat (4) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_res_data", 32'(res_data), 32'd0);
        chk("arst_res_id", 32'(res_id), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        n_disc = sb.size();
        sb.delete();
        mptr = 0;
        step();
        step();
        rst_n = 1'b1;
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        step();
        step();
        drain();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_count", 32'(n_pop + n_disc), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
